// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the ID, EX and MEM stages.
//   REG_AW / DATA_W : default register index and datapath widths
//   ALU_*           : 3-bit ALU operation encodings
//   ctrl_t          : packed decoded control carried down the pipeline
package cpu_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_SLL = 3'd7;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection, purely combinational.
//   ex_valid_i, ex_mem_read_i, ex_rd_i : state of the instruction currently in EX
//   id_valid_i, id_rs_i, id_rt_i       : instruction currently in ID
//   id_uses_rt_i                       : ID instruction actually reads rt
//   hazard_o                           : ID consumes the result of a load still in EX
module hazard_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    output logic              hazard_o
);

    logic rd_nonzero;
    logic src_match;

    always_comb begin
        rd_nonzero = (ex_rd_i != '0);
        src_match  = (ex_rd_i == id_rs_i) | (id_uses_rt_i & (ex_rd_i == id_rt_i));
        hazard_o   = ex_valid_i & ex_mem_read_i & rd_nonzero & id_valid_i & src_match;
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// downstream stall, branch flush and a saturating bubble counter.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   stall_i, flush_i        : hold all EX state / turn next EX entry into a bubble
//   id_*_i                  : decoded instruction, register file read data, immediate
//   wb_*_i                  : write-back port, bypassed into the operands
//   ex_*_o                  : registered EX-stage instruction
//   hazard_o                : combinational load-use stall request to PC and IF/ID
//   bubble_cnt_o            : saturating count of inserted load-use bubbles
module id_ex_pipe
    import cpu_pkg::ctrl_t;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_uses_rt_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              id_mem_to_reg_i,
    input  logic              id_alu_src_i,
    input  logic [2:0]        id_alu_op_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              ex_valid_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              ex_mem_to_reg_o,
    output logic              ex_alu_src_o,
    output logic [2:0]        ex_alu_op_o,
    output logic              hazard_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    // The register file returns the old value on a same-edge write, so the
    // write-back result is forwarded here. r0 may hold X and is never forwarded.
    function automatic logic [DATA_W-1:0] bypass(
        input logic [REG_AW-1:0] idx,
        input logic [DATA_W-1:0] rf_data,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        if (idx == '0) begin
            return '0;
        end else if (wb_we && (wb_rd == idx)) begin
            return wb_data;
        end
        return rf_data;
    endfunction

    ctrl_t             id_ctrl;
    ctrl_t             ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [REG_AW-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
    logic [DATA_W-1:0] rs_data_d, rs_data_q, rt_data_d, rt_data_q, imm_d, imm_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              hazard;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_i       (rd_q),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_uses_rt_i  (id_uses_rt_i),
        .hazard_o      (hazard)
    );

    always_comb begin
        id_ctrl = '{reg_write:  id_reg_write_i,
                    mem_read:   id_mem_read_i,
                    mem_write:  id_mem_write_i,
                    mem_to_reg: id_mem_to_reg_i,
                    alu_src:    id_alu_src_i,
                    alu_op:     id_alu_op_i};

        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        cnt_d     = cnt_q;

        if (stall_i) begin
            // hold everything
        end else if (flush_i || hazard) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            // A bubble coinciding with a flush is accounted as the flush.
            if (!flush_i && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            valid_d   = id_valid_i;
            ctrl_d    = id_valid_i ? id_ctrl : '0;
            rs_d      = id_rs_i;
            rt_d      = id_rt_i;
            rd_d      = id_rd_i;
            rs_data_d = bypass(id_rs_i, id_rs_data_i, wb_reg_write_i, wb_rd_i, wb_data_i);
            rt_data_d = bypass(id_rt_i, id_rt_data_i, wb_reg_write_i, wb_rd_i, wb_data_i);
            imm_d     = id_imm_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        ex_valid_o      = valid_q;
        ex_rs_o         = rs_q;
        ex_rt_o         = rt_q;
        ex_rd_o         = rd_q;
        ex_rs_data_o    = rs_data_q;
        ex_rt_data_o    = rt_data_q;
        ex_imm_o        = imm_q;
        ex_reg_write_o  = ctrl_q.reg_write;
        ex_mem_read_o   = ctrl_q.mem_read;
        ex_mem_write_o  = ctrl_q.mem_write;
        ex_mem_to_reg_o = ctrl_q.mem_to_reg;
        ex_alu_src_o    = ctrl_q.alu_src;
        ex_alu_op_o     = ctrl_q.alu_op;
        hazard_o        = hazard;
        bubble_cnt_o    = cnt_q;
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
ID/EX pipeline stage that sits directly downstream of the register file. It captures the two register read ports, the immediate and the decoded control into EX-stage registers. It also provides the write-back-to-decode bypass that the register file lacks: a write at the same posedge as the read still returns the old value. It detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register index width
CNT_W, 16, bubble counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
stall_i  in  1  downstream stall; hold all EX registers
flush_i  in  1  branch/jump flush; next EX entry is a bubble
id_valid_i  in  1  ID holds a real instruction
id_rs_i / id_rt_i / id_rd_i  in  REG_AW each  source indices and destination index
id_uses_rt_i  in  1  instruction reads rt (R-type, store, beq)
id_rs_data_i / id_rt_data_i  in  DATA_W each  register file ReadData1/ReadData2
id_imm_i  in  DATA_W  sign-extended immediate
id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i, id_alu_src_i  in  1 each  control bits
id_alu_op_i  in  3  ALU operation
wb_reg_write_i  in  1  write-back write enable (same signal as the register file RegWrite)
wb_rd_i  in  REG_AW  write-back destination
wb_data_i  in  DATA_W  write-back data
ex_valid_o  out  1  EX holds a real instruction
ex_rs_o / ex_rt_o / ex_rd_o  out  REG_AW each  registered indices
ex_rs_data_o / ex_rt_data_o / ex_imm_o  out  DATA_W each  registered operands
ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_alu_src_o  out  1 each  registered control
ex_alu_op_o  out  3  registered ALU op
hazard_o  out  1  load-use stall request to PC and IF/ID (combinational)
bubble_cnt_o  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (rst_i=1 at posedge): all ex_* outputs = 0, bubble_cnt_o = 0. hazard_o is therefore 0 in the next cycle. Reset overrides stall_i and flush_i.
- Operand select, per source, evaluated combinationally:
  - index == 0 → 0. Register 0 has no reset and may hold X; it is never forwarded.
  - else if wb_reg_write_i && wb_rd_i == index → wb_data_i.
  - else → register file data.
- hazard_o = ex_valid_o & ex_mem_read_o & (ex_rd_o != 0) & id_valid_i & ((ex_rd_o == id_rs_i) | (id_uses_rt_i & ex_rd_o == id_rt_i)).
- Update priority at posedge: rst_i > stall_i (hold everything) > flush_i (bubble) > hazard_o (bubble) > load.
- A bubble sets ex_valid_o and all five control bits to 0. Data and index registers may take any value.
- Load: all EX registers take the ID values and selected operands; ex_valid_o = id_valid_i. Control bits are forced to 0 when id_valid_i = 0.
- Latency: one cycle, ID → EX.
- bubble_cnt_o increments by 1 only on a posedge where a hazard bubble is actually inserted (not stalled, not flushed, not reset). It saturates at all-ones.
- flush_i together with hazard_o: the bubble counts as a flush and the counter is not incremented.
- stall_i held for N cycles: EX outputs stay constant. hazard_o continues to evaluate against the held EX state and the current ID inputs.
- Reset in the middle of a stall or bubble: takes effect at the next posedge; no pending state survives it.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_AW and DATA_W constants.
  - ALU op encodings (3-bit localparams).
  - Packed struct ctrl_t for the six control fields, used by the ID, EX and MEM stages.
- One sub-module: hazard_detect, purely combinational. It computes hazard_o from the EX state and the ID indices, and the main hazard detection unit reuses it later.
- Operand bypass stays inline as two instances of a small function.

Test Plan:
1. Reset check: rst_i=1 for 2 cycles with random inputs → every ex_* = 0, bubble_cnt_o = 0, hazard_o = 0.
2. Same-cycle bypass: id_rs_i=5, id_rs_data_i=0x11111111, wb_reg_write_i=1, wb_rd_i=5, wb_data_i=0xDEADBEEF → next cycle ex_rs_data_o = 0xDEADBEEF. Repeat with wb_rd_i=0 and id_rs_i=0 → ex_rs_data_o = 0.
3. Load-use: EX holds lw with rd=8 (mem_read=1); ID holds add with rs=8 → hazard_o=1. Next cycle ex_valid_o=0, ex_reg_write_o=0, bubble_cnt_o=1.
4. No false hazard: EX holds lw with rd=8; ID is addi with rt=8 and id_uses_rt_i=0 → hazard_o=0. Same setup with ex_rd_o=0 → hazard_o=0.
5. Stall plus flush: stall_i=1 and flush_i=1 for 3 cycles → EX outputs unchanged. Release stall_i with flush_i=1 → ex_valid_o=0 and bubble_cnt_o unchanged.
6. Saturation: with CNT_W=2, force 5 consecutive hazard bubbles → bubble_cnt_o reads 1, 2, 3, 3, 3.
